cp0_reg: RTL and testbench

- Coprocessor-0 register file for the 5-stage MIPS32 core.
- Write side consumes the write-back stage CP0 write triple: we_i, waddr_i, data_i. These are registered outputs of the MEM/WB pipeline register.
- Read side serves mfc0 in the execute stage, with forwarding of a same-cycle WB write.
- Also keeps the free-running Count timer, the Compare match timer interrupt, and samples external interrupt lines into Cause.

---
 rtl/cp0_reg_if.sv | 39 +++
 rtl/cp0_reg.sv | 148 ++++++++++++++
 tb/tb_cp0_reg.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_reg_if
// Description : CP0 access bus between the pipeline and the CP0 register
//               file. It carries the write-back write triple, the execute
//               stage read address, and the combinational read data.
//   we_i    : write enable from the WB stage
//   waddr_i : register number of the write (5 bits)
//   data_i  : write data (32 bits)
//   raddr_i : register number of the mfc0 read (5 bits)
//   data_o  : read data returned by CP0 (32 bits)
//   master  : pipeline side (drives the write triple and raddr_i)
//   slave   : CP0 side (returns data_o)
// Revision    : 1.0 - initial release
// ============================================================================
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_o;

  modport master (
    output we_i,
    output waddr_i,
    output data_i,
    output raddr_i,
    input  data_o
  );

  modport slave (
    input  we_i,
    input  waddr_i,
    input  data_i,
    input  raddr_i,
    output data_o
  );
endinterface
`default_nettype wire

// File: rtl/cp0_reg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_reg
// Description : Coprocessor-0 register file for the 5-stage MIPS32 core.
//               It holds Count, Compare, Status, Cause and EPC, and exposes
//               PRId and Config as constants. Count runs freely, and a match
//               with a non-zero Compare raises a sticky timer interrupt.
//               Cause.IP[7:2] samples the external interrupt lines. mfc0
//               reads are combinational and forward a same-cycle WB write.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               bus (slave)    - write triple, read address, read data
//               int_i[5:0]     - external interrupt lines (level)
//               count_o, compare_o, status_o, cause_o, epc_o,
//               config_o, prid_o - architectural register contents
//               timer_int_o    - registered timer interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
  parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  cp0_reg_if.slave         bus,
  input  wire logic [5:0]  int_i,
  output logic      [31:0] count_o,
  output logic      [31:0] compare_o,
  output logic      [31:0] status_o,
  output logic      [31:0] cause_o,
  output logic      [31:0] epc_o,
  output logic      [31:0] config_o,
  output logic      [31:0] prid_o,
  output logic             timer_int_o
);

  localparam logic [4:0]  c_addr_count   = 5'd9;
  localparam logic [4:0]  c_addr_compare = 5'd11;
  localparam logic [4:0]  c_addr_status  = 5'd12;
  localparam logic [4:0]  c_addr_cause   = 5'd13;
  localparam logic [4:0]  c_addr_epc     = 5'd14;
  localparam logic [4:0]  c_addr_prid    = 5'd15;
  localparam logic [4:0]  c_addr_config  = 5'd16;

  // Software-writable Cause bits: IV[23], WP[22], IP[1:0] (bits 9:8).
  localparam logic [31:0] c_cause_wr_mask = 32'h00C00300;

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic        r_timer_int;

  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_fwd;
  logic [31:0] w_cause_merged;
  logic [31:0] w_cause_next;
  logic        w_timer_match;
  logic [31:0] w_rdata;

  assign w_wr_count   = bus.we_i && (bus.waddr_i == c_addr_count);
  assign w_wr_compare = bus.we_i && (bus.waddr_i == c_addr_compare);
  assign w_wr_status  = bus.we_i && (bus.waddr_i == c_addr_status);
  assign w_wr_cause   = bus.we_i && (bus.waddr_i == c_addr_cause);
  assign w_wr_epc     = bus.we_i && (bus.waddr_i == c_addr_epc);

  // Cause as it would look after this cycle's software write, with the
  // hardware IP bits still showing the old sampled value. The read-forward
  // path uses this merged value.
  assign w_cause_merged = (r_cause & ~c_cause_wr_mask) | (bus.data_i & c_cause_wr_mask);

  // Hardware IP bits always follow int_i, whether or not software writes Cause.
  always_comb begin
    w_cause_next        = w_wr_cause ? w_cause_merged : r_cause;
    w_cause_next[15:10] = int_i;
  end

  // A Compare of zero is treated as disarmed.
  assign w_timer_match = (r_compare != 32'd0) && (r_count == r_compare);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= 32'd0;
      r_compare   <= 32'd0;
      r_status    <= STATUS_RESET;
      r_cause     <= 32'd0;
      r_epc       <= 32'd0;
      r_timer_int <= 1'b0;
    end else begin
      r_count <= w_wr_count ? bus.data_i : r_count + 32'd1;

      // A Compare write acknowledges the interrupt and also wins over a
      // match in the same cycle.
      if (w_wr_compare) begin
        r_compare   <= bus.data_i;
        r_timer_int <= 1'b0;
      end else if (w_timer_match) begin
        r_timer_int <= 1'b1;
      end

      if (w_wr_status) begin
        r_status <= bus.data_i;
      end
      if (w_wr_epc) begin
        r_epc <= bus.data_i;
      end
      r_cause <= w_cause_next;
    end
  end

  // A write in WB to the register that EX is reading is returned directly,
  // so mfc0 needs no stall. PRId and Config are constants, so they never
  // forward.
  assign w_fwd = bus.we_i && (bus.waddr_i == bus.raddr_i);

  always_comb begin
    w_rdata = 32'd0;
    if (!rst) begin
      case (bus.raddr_i)
        c_addr_count:   w_rdata = w_fwd ? bus.data_i : r_count;
        c_addr_compare: w_rdata = w_fwd ? bus.data_i : r_compare;
        c_addr_status:  w_rdata = w_fwd ? bus.data_i : r_status;
        c_addr_cause:   w_rdata = w_fwd ? w_cause_merged : r_cause;
        c_addr_epc:     w_rdata = w_fwd ? bus.data_i : r_epc;
        c_addr_prid:    w_rdata = PRID_VALUE;
        c_addr_config:  w_rdata = CONFIG_VALUE;
        default:        w_rdata = 32'd0;
      endcase
    end
  end

  assign bus.data_o  = w_rdata;
  assign count_o     = r_count;
  assign compare_o   = r_compare;
  assign status_o    = r_status;
  assign cause_o     = r_cause;
  assign epc_o       = r_epc;
  assign config_o    = CONFIG_VALUE;
  assign prid_o      = PRID_VALUE;
  assign timer_int_o = r_timer_int;

endmodule
`default_nettype wire

// File: tb/tb_cp0_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_reg
// Description : Self-checking bench for cp0_reg. A field-level reference
//               model advances on every rising edge. A compare process
//               checks every output against the model on each falling edge.
//               Directed stimulus adds literal expectations that pin the
//               model itself.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  int_i;
  logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int checks = 0;
  int errors = 0;

  cp0_reg_if bus();

  cp0_reg dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .int_i       (int_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .status_o    (status_o),
    .cause_o     (cause_o),
    .epc_o       (epc_o),
    .config_o    (config_o),
    .prid_o      (prid_o),
    .timer_int_o (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (architectural fields) ----------------
  bit          m_valid = 1'b0;
  logic [31:0] m_count, m_compare, m_status, m_epc;
  logic        m_timer;
  logic        m_iv, m_wp;
  logic [1:0]  m_ip_sw;
  logic [5:0]  m_ip_hw;

  function automatic logic [31:0] cause_of(input logic iv, input logic wp,
                                           input logic [5:0] hw, input logic [1:0] sw);
    return {8'h00, iv, wp, 6'b000000, hw, sw, 8'h00};
  endfunction

  always @(posedge clk) begin
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic        nt;
    wr = bus.we_i; a = bus.waddr_i; d = bus.data_i;
    if (rst) begin
      m_count = 0; m_compare = 0; m_status = 32'h10000000; m_epc = 0;
      m_timer = 0; m_iv = 0; m_wp = 0; m_ip_sw = 0; m_ip_hw = 0;
      m_valid = 1'b1;
    end else begin
      nt = m_timer;
      if (wr && a == 5'd11) nt = 1'b0;
      else if (m_compare != 0 && m_count == m_compare) nt = 1'b1;
      m_timer = nt;
      if (wr && a == 5'd9) m_count = d; else m_count = m_count + 1;
      if (wr && a == 5'd11) m_compare = d;
      if (wr && a == 5'd12) m_status = d;
      if (wr && a == 5'd14) m_epc = d;
      if (wr && a == 5'd13) begin
        m_iv = d[23]; m_wp = d[22]; m_ip_sw = d[9:8];
      end
      m_ip_hw = int_i;
    end
  end

  function automatic logic [31:0] exp_read();
    logic fwd;
    if (rst) return 32'd0;
    fwd = bus.we_i && (bus.waddr_i == bus.raddr_i);
    case (bus.raddr_i)
      5'd9:  return fwd ? bus.data_i : m_count;
      5'd11: return fwd ? bus.data_i : m_compare;
      5'd12: return fwd ? bus.data_i : m_status;
      5'd13: return fwd ? cause_of(bus.data_i[23], bus.data_i[22], m_ip_hw, bus.data_i[9:8])
                        : cause_of(m_iv, m_wp, m_ip_hw, m_ip_sw);
      5'd14: return fwd ? bus.data_i : m_epc;
      5'd15: return 32'h004c0102;
      5'd16: return 32'h00008000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("count",   count_o,   m_count);
      chk("compare", compare_o, m_compare);
      chk("status",  status_o,  m_status);
      chk("cause",   cause_o,   cause_of(m_iv, m_wp, m_ip_hw, m_ip_sw));
      chk("epc",     epc_o,     m_epc);
      chk("config",  config_o,  32'h00008000);
      chk("prid",    prid_o,    32'h004c0102);
      chk("timer",   {31'd0, timer_int_o}, {31'd0, m_timer});
      chk("data_o",  bus.data_o, exp_read());
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we_i = 1'b1; bus.waddr_i = a; bus.data_i = d;
  endtask

  task automatic idle();
    bus.we_i = 1'b0; bus.waddr_i = 5'd0; bus.data_i = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; int_i = 6'd0; idle(); bus.raddr_i = 5'd15;
    tick(); tick();
    chk("rst_status", status_o, 32'h10000000);
    chk("rst_config", config_o, 32'h00008000);
    chk("rst_prid",   prid_o,   32'h004c0102);
    chk("rst_count",  count_o,  32'd0);
    chk("rst_cause",  cause_o,  32'd0);
    chk("rst_epc",    epc_o,    32'd0);
    chk("rst_timer",  {31'd0, timer_int_o}, 32'd0);
    chk("rst_data_o", bus.data_o, 32'd0);
    rst = 1'b0;
    tick();
    chk("count_1", count_o, 32'd1);
    repeat (4) tick();
    chk("count_5", count_o, 32'd5);

    // Count wrap, with Compare=0 as Count passes zero
    bus.raddr_i = 5'd9;
    wr(5'd9, 32'hFFFFFFFE); tick(); idle();
    chk("wrap_0", count_o, 32'hFFFFFFFE);
    tick(); chk("wrap_1", count_o, 32'hFFFFFFFF);
    tick(); chk("wrap_2", count_o, 32'h00000000);
    tick(); chk("wrap_3", count_o, 32'h00000001);
    chk("cmp0_no_timer", {31'd0, timer_int_o}, 32'd0);

    // Timer match
    wr(5'd9, 32'h10); tick();
    chk("cnt_0x10", count_o, 32'h10);
    wr(5'd11, 32'h20); tick(); idle();
    for (int i = 0; i < 40 && count_o != 32'h20; i++) tick();
    chk("reach_0x20", count_o, 32'h20);
    chk("timer_pre", {31'd0, timer_int_o}, 32'd0);
    tick();
    chk("timer_set", {31'd0, timer_int_o}, 32'd1);
    repeat (3) tick();
    chk("timer_sticky", {31'd0, timer_int_o}, 32'd1);
    wr(5'd11, 32'h100); tick(); idle();
    chk("timer_ack", {31'd0, timer_int_o}, 32'd0);

    // Match coinciding with a Compare write: the write wins
    wr(5'd9, 32'hFF); tick(); idle();
    tick();
    chk("cnt_0x100", count_o, 32'h100);
    wr(5'd11, 32'h100); tick(); idle();
    chk("match_vs_write", {31'd0, timer_int_o}, 32'd0);
    tick();
    chk("match_vs_write2", {31'd0, timer_int_o}, 32'd0);

    // Cause masking and forwarding
    int_i = 6'b101010; bus.raddr_i = 5'd13;
    wr(5'd13, 32'hFFFFFFFF); tick(); idle();
    chk("cause_mask", cause_o, 32'h00C0AB00);
    wr(5'd13, 32'h0); #1;
    chk("cause_fwd", bus.data_o, 32'h0000A800);
    tick(); idle();
    chk("cause_sw_clr", cause_o, 32'h0000A800);
    int_i = 6'd0; tick();
    chk("cause_hw_clr", cause_o, 32'h0);

    // EPC / Status forwarding, read-only and unmapped registers
    bus.raddr_i = 5'd14; wr(5'd14, 32'hBFC00100); #1;
    chk("epc_fwd", bus.data_o, 32'hBFC00100);
    chk("epc_old", epc_o, 32'h0);
    tick(); idle();
    chk("epc_new", epc_o, 32'hBFC00100);
    bus.raddr_i = 5'd15; wr(5'd15, 32'hDEADBEEF); #1;
    chk("prid_nofwd", bus.data_o, 32'h004c0102);
    tick();
    bus.raddr_i = 5'd16; wr(5'd16, 32'h0); #1;
    chk("config_nofwd", bus.data_o, 32'h00008000);
    tick();
    bus.raddr_i = 5'd20; wr(5'd20, 32'h55AA55AA); #1;
    chk("unmapped", bus.data_o, 32'h0);
    tick();
    bus.raddr_i = 5'd12; wr(5'd12, 32'h12345678); #1;
    chk("status_fwd", bus.data_o, 32'h12345678);
    tick(); idle();
    chk("status_new", status_o, 32'h12345678);

    // Reset mid-operation with a pending timer and a Status write
    wr(5'd11, 32'h1231); tick();
    wr(5'd9, 32'h1230); tick(); idle();
    repeat (2) tick();
    chk("mid_timer", {31'd0, timer_int_o}, 32'd1);
    repeat (2) tick();
    chk("mid_count", count_o, 32'h1234);
    rst = 1'b1; wr(5'd12, 32'hFFFFFFFF); tick(); idle();
    chk("mr_count",  count_o,   32'h0);
    chk("mr_cmp",    compare_o, 32'h0);
    chk("mr_status", status_o,  32'h10000000);
    chk("mr_timer",  {31'd0, timer_int_o}, 32'd0);
    chk("mr_data_o", bus.data_o, 32'h0);
    rst = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
